// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD-byte header from the front of each AXI-Stream
// packet. The header leaves on its own single-beat port, right-justified in
// the low H byte lanes. The payload is re-aligned so that it starts in
// lane 0 (MSB byte first).
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_cfg,
    input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
    output logic                    ready_cfg,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    output logic                    short_err,
    input  logic                    ready_header
);

    // Byte counts range over 0..DATA_BYTE_WD, one value wider than the cfg code.
    localparam int CW = $clog2(DATA_BYTE_WD + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // Number of enabled bytes in a contiguous keep vector.
    function automatic int count_ones(input logic [DATA_BYTE_WD-1:0] kp);
        int n;
        n = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) n += int'(kp[i]);
        return n;
    endfunction

    // Keep vector with the n most significant (earliest) lanes enabled.
    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input int n);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < n);
        return m;
    endfunction

    // Expand a keep vector into a bit mask over the data bus.
    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] kp);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{kp[i]}};
        return m;
    endfunction

    logic [1:0]              r_state;
    logic [CW-1:0]           r_hlen;
    logic [DATA_WD-1:0]      r_res;
    logic [CW-1:0]           r_rcnt;

    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;

    logic                    r_valid_header;
    logic [DATA_WD-1:0]      r_data_header;
    logic [DATA_BYTE_WD-1:0] r_keep_header;
    logic                    r_short_err;

    logic                    w_ready_in;
    logic                    w_in_acc;
    int                      w_k;
    int                      w_h;
    int                      w_r;
    int                      w_n;
    logic [DATA_WD-1:0]      w_din;
    logic [DATA_WD-1:0]      w_hdr_data;
    logic [DATA_BYTE_WD-1:0] w_hdr_keep;
    logic                    w_hdr_short;
    logic [DATA_WD-1:0]      w_hdr_res;
    logic [CW-1:0]           w_hdr_rcnt;
    logic [DATA_WD-1:0]      w_body_data;
    logic [DATA_BYTE_WD-1:0] w_body_keep;
    logic                    w_body_last;
    logic [DATA_WD-1:0]      w_body_res;
    logic [CW-1:0]           w_body_rcnt;

    // Input acceptance: HDR waits on the header register, BODY on the payload register.
    always_comb begin
        w_ready_in = 1'b0;
        case (r_state)
            S_HDR:   w_ready_in = !r_valid_header || ready_header;
            S_BODY:  w_ready_in = !r_valid_out || ready_out;
            default: w_ready_in = 1'b0;
        endcase
        if (rst) w_ready_in = 1'b0;
    end

    assign w_in_acc  = valid_in && w_ready_in;
    assign ready_in  = w_ready_in;
    assign ready_cfg = (r_state == S_IDLE) && !rst;

    // Byte-lane arithmetic for the header split and the payload re-alignment.
    always_comb begin
        w_k   = count_ones(keep_in);
        w_h   = int'(r_hlen);
        w_r   = int'(r_rcnt);
        w_n   = w_r + w_k;
        // Disabled lanes are zeroed so they never leak into header or payload.
        w_din = data_in & lane_mask(keep_in);

        // Header bytes 0..H-1 slide down into lanes W-H..W-1.
        w_hdr_data  = w_din >> (8 * (DATA_BYTE_WD - w_h));
        w_hdr_keep  = keep_in >> (DATA_BYTE_WD - w_h);
        w_hdr_short = (w_k < w_h);
        w_hdr_res   = w_din << (8 * w_h);
        w_hdr_rcnt  = (w_k > w_h) ? CW'(w_k - w_h) : '0;

        // Residue occupies lanes 0..R-1; the new beat fills in behind it.
        w_body_data = r_res | (w_din >> (8 * w_r));
        w_body_keep = msb_ones(w_n);
        w_body_last = last_in && (w_n <= DATA_BYTE_WD);
        w_body_res  = w_din << (8 * (DATA_BYTE_WD - w_r));
        w_body_rcnt = (w_n > DATA_BYTE_WD) ? CW'(w_n - DATA_BYTE_WD) : '0;
    end

    // Packet FSM with registered header and payload outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_hlen         <= '0;
            r_res          <= '0;
            r_rcnt         <= '0;
            r_valid_out    <= 1'b0;
            r_data_out     <= '0;
            r_keep_out     <= '0;
            r_last_out     <= 1'b0;
            r_valid_header <= 1'b0;
            r_data_header  <= '0;
            r_keep_header  <= '0;
            r_short_err    <= 1'b0;
        end else begin
            if (r_valid_header && ready_header) r_valid_header <= 1'b0;
            if (r_valid_out && ready_out)       r_valid_out    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (valid_cfg) begin
                        r_hlen  <= CW'(byte_extract_cnt) + CW'(1);
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_in_acc) begin
                        r_valid_header <= 1'b1;
                        r_data_header  <= w_hdr_data;
                        r_keep_header  <= w_hdr_keep;
                        r_short_err    <= w_hdr_short;
                        r_res          <= w_hdr_res;
                        r_rcnt         <= w_hdr_rcnt;
                        if (!last_in)               r_state <= S_BODY;
                        else if (w_hdr_rcnt != '0)  r_state <= S_FLUSH;
                        else                        r_state <= S_IDLE;
                    end
                end
                S_BODY: begin
                    if (w_in_acc) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= w_body_data;
                        r_keep_out  <= w_body_keep;
                        r_last_out  <= w_body_last;
                        r_res       <= w_body_res;
                        r_rcnt      <= w_body_rcnt;
                        if (last_in) r_state <= w_body_last ? S_IDLE : S_FLUSH;
                    end
                end
                default: begin
                    // Leftover bytes of the last beat go out as a final short beat.
                    if (!r_valid_out || ready_out) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_res;
                        r_keep_out  <= msb_ones(int'(r_rcnt));
                        r_last_out  <= 1'b1;
                        r_res       <= '0;
                        r_rcnt      <= '0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign valid_header = r_valid_header;
    assign data_header  = r_data_header;
    assign keep_header  = r_keep_header;
    assign short_err    = r_short_err;

endmodule
